// File: rtl/gray_mon_pkg.sv
// Shared state encoding, error codes and Gray decode for the gray_monitor slice.
package gray_mon_pkg;

  localparam int unsigned BIN_W = 3;

  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t ACQUIRE = 2'd1;
  localparam state_t LOCKED  = 2'd2;
  localparam state_t FAULT   = 2'd3;

  typedef logic [1:0] err_code_t;
  localparam err_code_t ERR_NONE         = 2'd0;
  localparam err_code_t ERR_ILLEGAL      = 2'd1;
  localparam err_code_t ERR_OVF_MISMATCH = 2'd2;
  localparam err_code_t ERR_OVF_DROP     = 2'd3;

  function automatic logic [BIN_W-1:0] gray2bin(input logic [BIN_W-1:0] g);
    logic [BIN_W-1:0] b;
    b[2] = g[2];
    b[1] = g[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// 3-bit combinational Gray-to-binary converter.
module gray_to_bin
  import gray_mon_pkg::*;
(
  input  logic [BIN_W-1:0] gray,
  output logic [BIN_W-1:0] bin_c
);

  assign bin_c = gray2bin(gray);

endmodule

// File: rtl/gray_monitor.sv
// Checks a 3-bit Gray counter stream for legal hold/+1 steps, counts wraps, reports lock/fault.
// Optional macro GRAY_MON_TRACE_EN builds the ErrPrev/ErrCur fault capture registers.
module gray_monitor
  import gray_mon_pkg::*;
#(
  parameter int unsigned WRAP_W   = 8,
  parameter int unsigned LOCK_LEN = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clear,
  input  logic              Valid,
  input  logic [BIN_W-1:0]  GrayIn,
  input  logic              OverflowIn,
  output logic [BIN_W-1:0]  BinOut,
  output logic              Step,
  output logic              Wrap,
  output logic [WRAP_W-1:0] WrapCount,
  output logic              Locked,
  output logic              Error,
  output logic [1:0]        ErrCode,
  output logic [BIN_W-1:0]  ErrPrev,
  output logic [BIN_W-1:0]  ErrCur
);

  state_t            state_q, state_d;
  logic [BIN_W-1:0]  prev_q, prev_d;
  logic              ovf_q, ovf_d;
  logic [2:0]        run_q, run_d, run_inc;
  logic [BIN_W-1:0]  cur;
  logic [BIN_W-1:0]  delta;
  logic              is_step, is_wrap, ovf_rise, ovf_fall, upstream_rst;
  logic              checking, fault_hit;
  err_code_t         err_c;
  logic [BIN_W-1:0]  bin_d;
  logic              step_d, wrap_d;
  logic [WRAP_W-1:0] wcnt_d;
  err_code_t         code_d;

  gray_to_bin u_g2b (
    .gray  (GrayIn),
    .bin_c (cur)
  );

  // Sample classifier; an overflow fall onto zero is an upstream reset, not a fault
  always_comb begin
    delta        = cur - prev_q;
    is_step      = (delta == 3'd1);
    is_wrap      = is_step && (prev_q == 3'd7);
    ovf_rise     = !ovf_q && OverflowIn;
    ovf_fall     = ovf_q && !OverflowIn;
    upstream_rst = ovf_fall && (cur == 3'd0);
    err_c        = ERR_NONE;
    if (delta > 3'd1)
      err_c = ERR_ILLEGAL;
    else if ((ovf_rise && !is_wrap) || (is_wrap && !OverflowIn))
      err_c = ERR_OVF_MISMATCH;
    else if (ovf_fall)
      err_c = ERR_OVF_DROP;
    checking  = Valid && !Clear && !upstream_rst &&
                ((state_q == ACQUIRE) || (state_q == LOCKED));
    fault_hit = checking && (err_c != ERR_NONE);
    run_inc   = run_q + 3'd1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (Clear) begin
      state_d = IDLE;
    end else if (Valid) begin
      case (state_q)
        IDLE:    state_d = ACQUIRE;
        ACQUIRE: begin
          if (upstream_rst)                             state_d = ACQUIRE;
          else if (fault_hit)                           state_d = FAULT;
          else if (is_step && (run_inc == 3'(LOCK_LEN))) state_d = LOCKED;
        end
        LOCKED: begin
          if (upstream_rst)   state_d = ACQUIRE;
          else if (fault_hit) state_d = FAULT;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Next values for the datapath registers
  always_comb begin
    prev_d = prev_q;
    ovf_d  = ovf_q;
    run_d  = run_q;
    bin_d  = BinOut;
    step_d = 1'b0;
    wrap_d = 1'b0;
    wcnt_d = WrapCount;
    code_d = ErrCode;
    if (Clear) begin
      run_d  = 3'd0;
      wcnt_d = '0;
      code_d = ERR_NONE;
    end else if (Valid) begin
      bin_d = cur;
      case (state_q)
        IDLE: begin
          prev_d = cur;
          ovf_d  = OverflowIn;
          run_d  = 3'd0;
        end
        ACQUIRE, LOCKED: begin
          if (upstream_rst) begin
            prev_d = 3'd0;
            ovf_d  = 1'b0;
            run_d  = 3'd0;
          end else begin
            prev_d = cur;
            ovf_d  = OverflowIn;
            step_d = is_step;
            wrap_d = is_wrap;
            if (is_wrap && (WrapCount != {WRAP_W{1'b1}}))
              wcnt_d = WrapCount + WRAP_W'(1);
            if (is_step && (state_q == ACQUIRE))
              run_d = run_inc;
            if (fault_hit)
              code_d = err_c;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      prev_q    <= '0;
      ovf_q     <= 1'b0;
      run_q     <= 3'd0;
      BinOut    <= '0;
      Step      <= 1'b0;
      Wrap      <= 1'b0;
      WrapCount <= '0;
      Locked    <= 1'b0;
      Error     <= 1'b0;
      ErrCode   <= ERR_NONE;
    end else begin
      prev_q    <= prev_d;
      ovf_q     <= ovf_d;
      run_q     <= run_d;
      BinOut    <= bin_d;
      Step      <= step_d;
      Wrap      <= wrap_d;
      WrapCount <= wcnt_d;
      Locked    <= (state_d == LOCKED);
      Error     <= (state_d == FAULT);
      ErrCode   <= code_d;
    end
  end

`ifdef GRAY_MON_TRACE_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ErrPrev <= '0;
      ErrCur  <= '0;
    end else if (fault_hit) begin
      ErrPrev <= prev_q;
      ErrCur  <= cur;
    end
  end
`else
  assign ErrPrev = '0;
  assign ErrCur  = '0;
`endif

endmodule

// File: doc/gray_monitor.md
# gray_monitor

Downstream consumer of the 3-bit Gray counter stage. Samples the counter's Gray output and overflow flag on a strobe and converts Gray to binary. Checks that every observed transition is a legal hold or +1 step and counts wrap-arounds. Reports lock and fault status to the surrounding test or debug logic.

## Interface

Parameters:
- WRAP_W, 8: width of the wrap counter; the counter saturates at 2^WRAP_W-1.
- LOCK_LEN, 2: number of consecutive legal +1 steps needed to go from ACQUIRE to LOCKED; range 1..7.

Ports:
- Clk, input, 1: the only clock; all state updates on its rising edge.
- Reset, input, 1: asynchronous, active-low reset; Reset=0 forces the reset state immediately.
- Clear, input, 1: synchronous clear; returns to IDLE and zeroes WrapCount, Error and ErrCode.
- Valid, input, 1: sample strobe, one sample per high cycle; driven from the upstream enable.
- GrayIn, input, 3: Gray code from the upstream counter.
- OverflowIn, input, 1: sticky overflow flag from the upstream counter.
- BinOut, output, 3: registered binary value of the last sample.
- Step, output, 1: one-cycle pulse on each legal +1 step.
- Wrap, output, 1: one-cycle pulse on each 7 to 0 step.
- WrapCount, output, WRAP_W: saturating count of wraps.
- Locked, output, 1: high while the state is LOCKED.
- Error, output, 1: sticky fault flag; high while the state is FAULT.
- ErrCode, output, 2: cause of the first fault.
  - 0: none.
  - 1: ILLEGAL, a multi-bit jump.
  - 2: OVF_MISMATCH, overflow flag inconsistent with wraps.
  - 3: OVF_DROP, overflow flag fell without an upstream reset pattern.
- ErrPrev, output, 3: binary value before the faulting sample.
- ErrCur, output, 3: binary value of the faulting sample.

## Operation

- Per Valid sample, compute cur = gray2bin(GrayIn) and delta = (cur − prev) mod 8, using 3-bit wrap arithmetic.
- Classify the sample:
  - delta 0: HOLD.
  - delta 1: STEP; a STEP with prev=7 and cur=0 is also a WRAP.
  - any other delta: ILLEGAL.
- Overflow checks; ovf_q is the previous OverflowIn sample:
  - OverflowIn rises (0 to 1) on a non-WRAP sample: OVF_MISMATCH.
  - A WRAP occurs while OverflowIn=0: OVF_MISMATCH.
  - OverflowIn falls (1 to 0) with cur=0: upstream reset. Go to ACQUIRE with prev=0 and no error. WrapCount is kept.
  - OverflowIn falls with cur≠0: OVF_DROP.
- States, with encoding in the package:
  - IDLE: the first Valid loads prev and ovf_q and goes to ACQUIRE. No classification is done and Step/Wrap stay low.
  - ACQUIRE: HOLD keeps the step run. STEP increments run; when run reaches LOCK_LEN, go to LOCKED. ILLEGAL or any overflow error goes to FAULT.
  - LOCKED: HOLD and STEP stay in LOCKED. Errors go to FAULT.
  - FAULT: sticky. Valid samples still update BinOut, but no other outputs change. Exit only via Clear (to IDLE) or Reset.
- Error priority when several conditions hit on one sample: ILLEGAL, then OVF_MISMATCH, then OVF_DROP.
- ErrCode, ErrPrev and ErrCur are captured only on entry to FAULT.
- A WRAP increments WrapCount (saturating) even on the same sample that raises OVF_MISMATCH.
- Without Valid, nothing changes except that the Step and Wrap pulses deassert.

## Timing

- All outputs are registered; the response appears on the cycle after the Valid edge (1-cycle latency).
- Step and Wrap are high for exactly one cycle per qualifying sample. Back-to-back Valid cycles give back-to-back pulses.
- Reset=0, asynchronous:
  - state=IDLE.
  - BinOut, Step, Wrap, WrapCount, Locked, Error and ErrCode are 0.
  - ErrPrev and ErrCur are 0.
  - run=0, prev=0, ovf_q=0.
- Reset asserted mid-sample aborts it; no partial update survives.
- Clear and Valid in the same cycle: Clear wins and the sample is discarded.
- WrapCount at its maximum stays at the maximum; Wrap still pulses.

## Configuration

- GRAY_MON_TRACE_EN:
  - Defined: ErrPrev and ErrCur capture the faulting pair as described above.
  - Undefined: both ports are tied to 0, the capture registers are not built, and all other behaviour is identical.

## Structure

- Package gray_mon_pkg holds:
  - State localparams: IDLE, ACQUIRE, LOCKED, FAULT.
  - ErrCode constants: ERR_NONE, ERR_ILLEGAL, ERR_OVF_MISMATCH, ERR_OVF_DROP.
  - The gray2bin function definition.
- One sub-module, gray_to_bin: a 3-bit combinational converter giving b[2]=g[2], b[1]=g[2]^g[1], b[0]=b[1]^g[0].
- The top level holds the FSM, the classifier and the counters.

## Test plan

- Reset, then Valid on Gray 000,001,011,010 with OverflowIn=0 → BinOut 0,1,2,3. Step pulses 3 times; Locked=1 after the 2nd step (LOCK_LEN=2); Error=0.
- Full cycle to binary 7, then Gray 000 with OverflowIn rising → Wrap pulse and WrapCount=1; no error.
- From binary 2 (Gray 011), sample Gray 111 (binary 5) → next cycle Error=1, ErrCode=1, Locked=0. With trace enabled, ErrPrev=2 and ErrCur=5.
- Reach binary 3, then OverflowIn rises while sampling binary 4 → ErrCode=2. Next, assert Clear together with Valid → state IDLE, Error=0, WrapCount=0, and the sample is ignored.
- After a wrap with OverflowIn=1, sample Gray 000 with OverflowIn=0 → ACQUIRE, Error=0, WrapCount unchanged. The same fall with Gray 010 → ErrCode=3.
- WRAP_W=2 with 5 wraps → WrapCount saturates at 3 and Wrap pulses 5 times. Drop Reset mid-run → all outputs read 0 before the next Clk edge.
